// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t      FSM states (IDLE / SHIFT / DONE)
//   NIBBLE_W     width of one BCD digit
//   ADJ_THRESH   digit value at or above which +ADJ_ADD is applied before a shift
//   ADJ_ADD      double-dabble correction
//   min_digits() decimal digits needed to hold 2**bin_w-1 exactly
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W   = 4;
    localparam logic [3:0]  ADJ_THRESH = 4'd5;
    localparam logic [3:0]  ADJ_ADD    = 4'd3;

    // Elaboration-time helper: number of decimal digits of 2**bin_w-1.
    function automatic int unsigned min_digits(input int unsigned bin_w);
        longint unsigned v;
        int unsigned     d;
        v = (64'd1 << bin_w) - 64'd1;
        d = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            if (v != 0) begin
                d++;
                v = v / 10;
            end
        end
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle between a requester and bin2bcd_seq.
//   start  request a conversion (master -> slave)
//   bin    binary operand      (master -> slave)
//   busy   conversion running  (slave -> master)
//   done   one-cycle result strobe
//   bcd    packed BCD result, digit 0 in bcd[3:0]
//   ovf    value did not fit (only when BIN2BCD_OVF_EN is defined)
interface bin2bcd_seq_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    import bin2bcd_pkg::*;

    logic                         start;
    logic [BIN_W-1:0]             bin;
    logic                         busy;
    logic                         done;
    logic [NIBBLE_W*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_OVF_EN
    logic                         ovf;

    modport master (output start, bin, input busy, done, bcd, ovf);
    modport slave  (input start, bin, output busy, done, bcd, ovf);
`else
    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);
`endif

endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction for one BCD nibble.
//   din   current digit (0..9)
//   dout  din+3 when din>=5, else din; the following left shift then yields a valid digit
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3), one input bit per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bin2bcd_seq_if slave: start/bin in, busy/done/bcd(/ovf) out
// Optional feature: define BIN2BCD_OVF_EN to add the sticky overflow flag (bus.ovf).
// Timing: start accepted in cycle 0 -> SHIFT in cycles 1..BIN_W -> DONE (done=1) in cycle BIN_W+1.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    bin2bcd_seq_if.slave      bus
);

    localparam int unsigned BCD_W  = NIBBLE_W * DIGITS;
    localparam int unsigned SREG_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t              state_q, state_d;
    logic [SREG_W-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;

    logic [BCD_W-1:0]    adj_digits;
    logic [SREG_W-1:0]   sreg_shl;
    logic                last_bit;
    logic                lost_bit;

    // Correct every digit nibble in parallel before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sreg_q[BIN_W + g*NIBBLE_W +: NIBBLE_W]),
            .dout (adj_digits[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    // Top bit of the corrected digit field falls off the end of the register.
    assign sreg_shl = {adj_digits[BCD_W-2:0], sreg_q[BIN_W-1:0], 1'b0};
    assign lost_bit = adj_digits[BCD_W-1];
    assign last_bit = (cnt_q == CNT_W'(BIN_W - 1));

`ifdef BIN2BCD_OVF_EN
    // Overflow is impossible when DIGITS covers the full input range.
    localparam bit CAN_OVF = (DIGITS < min_digits(BIN_W));

    logic ovf_r_q, ovf_r_d;
    logic ovf_q, ovf_d;
    logic ovf_now;

    assign ovf_now = CAN_OVF && (ovf_r_q || lost_bit);
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
`ifdef BIN2BCD_OVF_EN
        ovf_r_d = ovf_r_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sreg_d  = {{BCD_W{1'b0}}, bus.bin};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
`ifdef BIN2BCD_OVF_EN
                    ovf_r_d = 1'b0;
                    ovf_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                sreg_d = sreg_shl;
                cnt_d  = cnt_q + CNT_W'(1);
`ifdef BIN2BCD_OVF_EN
                ovf_r_d = ovf_now;
`endif
                // Result registers load on the edge into DONE so that bcd
                // is already valid in the cycle done is high.
                if (last_bit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    bcd_d   = sreg_shl[SREG_W-1 -: BCD_W];
`ifdef BIN2BCD_OVF_EN
                    ovf_d   = ovf_now;
`endif
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
        end
    end

`ifdef BIN2BCD_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_r_q <= ovf_r_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: three instances (8b/3 digits, 8b/2 digits,
// 12b/4 digits) checked against a decimal reference model.
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if8();
    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) if2();
    bin2bcd_seq_if #(.BIN_W(12), .DIGITS(4)) if12();

    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(2)) u_dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));
    bin2bcd_seq #(.BIN_W(12), .DIGITS(4)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(if12));

    logic        start_r[3];
    logic [31:0] bin_r[3];
    logic        done_w[3];
    logic        busy_w[3];
    logic [63:0] bcd_w[3];

    assign if8.start  = start_r[0];
    assign if2.start  = start_r[1];
    assign if12.start = start_r[2];
    assign if8.bin    = bin_r[0][7:0];
    assign if2.bin    = bin_r[1][7:0];
    assign if12.bin   = bin_r[2][11:0];

    assign done_w[0] = if8.done;
    assign done_w[1] = if2.done;
    assign done_w[2] = if12.done;
    assign busy_w[0] = if8.busy;
    assign busy_w[1] = if2.busy;
    assign busy_w[2] = if12.busy;
    assign bcd_w[0]  = 64'(if8.bcd);
    assign bcd_w[1]  = 64'(if2.bcd);
    assign bcd_w[2]  = 64'(if12.bcd);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal reference: value mod 10**dg, one digit per nibble.
    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int dg);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < dg; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // One conversion on instance sel; entered and left at a negedge.
    task automatic run_conv(input int sel, input longint unsigned v, input int bw, input int dg);
        int          first_done;
        int          n_done;
        logic [63:0] exp;
        logic [63:0] got;
        first_done = -1;
        n_done     = 0;
        exp        = ref_bcd(v, dg);
        got        = '0;
        bin_r[sel]   = 32'(v);
        start_r[sel] = 1'b1;
        for (int cyc = 1; cyc <= bw + 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start_r[sel] = 1'b0;
                bin_r[sel]   = $urandom;
                check("busy_after_start", 64'(busy_w[sel]), 64'd1);
            end
            if (cyc == bw + 2) check("busy_back_low", 64'(busy_w[sel]), 64'd0);
            if (done_w[sel]) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = cyc;
                    got        = bcd_w[sel];
                end
            end
        end
        check("done_cycle", 64'(first_done), 64'(bw + 1));
        check("done_count", 64'(n_done), 64'd1);
        check("bcd_value", got, exp);
        check("bcd_held", bcd_w[sel], exp);
        for (int i = 0; i < dg; i++) begin
            check("digit_le_9", 64'(got[4*i +: 4] <= 4'd9), 64'd1);
        end
    endtask

    initial begin
        int first_dn;
        int second_dn;
        int n_dn;
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            bin_r[i]   = '0;
        end

        // Reset held 3 cycles, then idle with no start.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", 64'(busy_w[i]), 64'd0);
            check("rst_done", 64'(done_w[i]), 64'd0);
            check("rst_bcd",  bcd_w[i], 64'd0);
        end
`ifdef BIN2BCD_OVF_EN
        check("rst_ovf", 64'(if2.ovf), 64'd0);
`endif
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("idle_done", 64'(done_w[i]), 64'd0);
            check("idle_bcd",  bcd_w[i], 64'd0);
        end

        // Directed 8b/3-digit cases.
        run_conv(0, 255, 8, 3);
        run_conv(0, 0,   8, 3);
        run_conv(0, 99,  8, 3);

        // Start held for 20 cycles: accepts at cycles 0 and 10 only.
        first_dn  = -1;
        second_dn = -1;
        n_dn      = 0;
        bin_r[0]   = 32'd128;
        start_r[0] = 1'b1;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            if (cyc == 20) start_r[0] = 1'b0;
            if (done_w[0]) begin
                n_dn++;
                if (first_dn < 0) first_dn = cyc;
                else if (second_dn < 0) second_dn = cyc;
                check("held_bcd", bcd_w[0], ref_bcd(128, 3));
            end
        end
        check("held_done_count", 64'(n_dn), 64'd2);
        check("held_first_done", 64'(first_dn), 64'd9);
        check("held_second_done", 64'(second_dn), 64'd19);

        // Truncating 2-digit instance.
        run_conv(1, 123, 8, 2);
`ifdef BIN2BCD_OVF_EN
        check("ovf_set", 64'(if2.ovf), 64'd1);
`endif
        run_conv(1, 42, 8, 2);
`ifdef BIN2BCD_OVF_EN
        check("ovf_clear", 64'(if2.ovf), 64'd0);
`endif
        run_conv(1, 255, 8, 2);

        // Reset in the middle of a conversion.
        bin_r[0]   = 32'd200;
        start_r[0] = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start_r[0] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_w[0]), 64'd0);
        check("midrst_bcd",  bcd_w[0], 64'd0);
        check("midrst_done", 64'(done_w[0]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_dn = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (done_w[0]) n_dn++;
        end
        check("midrst_no_done", 64'(n_dn), 64'd0);
        check("midrst_bcd_after", bcd_w[0], 64'd0);

        // 12b/4-digit: boundaries then random sweep.
        run_conv(2, 0,    12, 4);
        run_conv(2, 4095, 12, 4);
        for (int k = 0; k < 500; k++) begin
            run_conv(2, longint'($urandom_range(4095, 0)), 12, 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
